// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared register-file constants and address type
package riscv_pkg;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    typedef logic [REG_AW-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - per-register busy bits for issue-stage RAW hazard detection
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*REG_AW-1:0]   raddr,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR*REG_AW-1:0]   waddr,
    input  logic [NWR-1:0]          alloc_en,
    input  logic [NWR*REG_AW-1:0]   alloc_addr,
    output logic [NRD-1:0]          rbusy,
    output logic [NUM_REGS-1:0]     busy_vec
);
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;
    logic [NRD-1:0]      hit_vec;

    // A new allocation overrides a completing write: the newer producer is still outstanding.
    always_comb begin
        set_vec  = '0;
        clr_vec  = '0;
        busy_nxt = busy_q;
        for (int i = 1; i < NUM_REGS; i++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && waddr[w*REG_AW +: REG_AW] == reg_addr_t'(i))
                    clr_vec[i] = 1'b1;
                if (alloc_en[w] && alloc_addr[w*REG_AW +: REG_AW] == reg_addr_t'(i))
                    set_vec[i] = 1'b1;
            end
            if (set_vec[i])
                busy_nxt[i] = 1'b1;
            else if (clr_vec[i])
                busy_nxt[i] = 1'b0;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            busy_q <= '0;
        else
            busy_q <= busy_nxt;
    end

    always_comb begin
        hit_vec = '0;
        rbusy   = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int w = 0; w < NWR; w++) begin
                if (wen[w] && waddr[w*REG_AW +: REG_AW] == raddr[r*REG_AW +: REG_AW])
                    hit_vec[r] = 1'b1;
            end
            rbusy[r] = busy_q[raddr[r*REG_AW +: REG_AW]]
                       & ~((BYPASS != 0) && hit_vec[r]);
        end
    end

    assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port integer register file with x0 hardwired zero and optional bypass
module reg_file_mp
    import riscv_pkg::*;
#(
    parameter int XLEN   = riscv_pkg::XLEN,
    parameter int NRD    = 4,
    parameter int NWR    = 2,
    parameter int BYPASS = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NRD*REG_AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0]     rdata,
    output logic [NRD-1:0]          rbusy,
    input  logic [NWR-1:0]          wen,
    input  logic [NWR*REG_AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0]     wdata,
    input  logic [NWR-1:0]          alloc_en,
    input  logic [NWR*REG_AW-1:0]   alloc_addr,
    output logic [NUM_REGS-1:0]     busy_vec
);
    logic [XLEN-1:0] regs [1:NUM_REGS-1];

    // Ports scanned ascending so the youngest (highest-index) writer's assignment lands last.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wen[w] && waddr[w*REG_AW +: REG_AW] == reg_addr_t'(i))
                        regs[i] <= wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (raddr[r*REG_AW +: REG_AW] == reg_addr_t'(i))
                    rdata[r*XLEN +: XLEN] = regs[i];
            end
            // Forwarding is suppressed during reset so reads show the cleared state.
            if (BYPASS != 0 && !reset && raddr[r*REG_AW +: REG_AW] != '0) begin
                for (int w = 0; w < NWR; w++) begin
                    if (wen[w] && waddr[w*REG_AW +: REG_AW] == raddr[r*REG_AW +: REG_AW])
                        rdata[r*XLEN +: XLEN] = wdata[w*XLEN +: XLEN];
                end
            end
        end
    end

    reg_scoreboard #(
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .raddr      (raddr),
        .wen        (wen),
        .waddr      (waddr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .rbusy      (rbusy),
        .busy_vec   (busy_vec)
    );
endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - directed self-checking bench for bypass and non-bypass register files
module tb_reg_file_mp;
    localparam int XLEN = 64;
    localparam int NRD  = 4;
    localparam int NWR  = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NRD*5-1:0]    raddr;
    logic [NRD*XLEN-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]      rbusy_b, rbusy_n;
    logic [NWR-1:0]      wen;
    logic [NWR*5-1:0]    waddr;
    logic [NWR*XLEN-1:0] wdata;
    logic [NWR-1:0]      alloc_en;
    logic [NWR*5-1:0]    alloc_addr;
    logic [31:0]         busy_b, busy_n;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_b (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_b)
    );

    reg_file_mp #(.XLEN(XLEN), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_n (
        .clk(clk), .reset(reset), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .busy_vec(busy_n)
    );

    task automatic idle();
        wen = '0; waddr = '0; wdata = '0; alloc_en = '0; alloc_addr = '0;
    endtask

    task automatic set_wr(input int w, input logic [4:0] a, input logic [XLEN-1:0] d);
        wen[w] = 1'b1;
        waddr[w*5 +: 5] = a;
        wdata[w*XLEN +: XLEN] = d;
    endtask

    task automatic set_alloc(input int w, input logic [4:0] a);
        alloc_en[w] = 1'b1;
        alloc_addr[w*5 +: 5] = a;
    endtask

    function automatic logic [XLEN-1:0] rd_b(input int r);
        return rdata_b[r*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] rd_n(input int r);
        return rdata_n[r*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        reset = 1'b1; idle(); raddr = {5'd5, 5'd5, 5'd9, 5'd5};
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (busy_b !== 32'h0 || busy_n !== 32'h0) begin
            errors++; $display("FAIL reset_busy got %h/%h want 0", busy_b, busy_n);
        end
        checks++;
        if (rdata_b !== '0 || rdata_n !== '0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rdata_b);
        end
        @(negedge clk);
        set_wr(0, 5'd5, 64'h1234); set_alloc(1, 5'd6);
        @(negedge clk); idle();
        #1;
        checks++;
        if (rd_n(0) !== 64'h1234 || busy_n[6] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_x5 got %h busy6=%b want 1234/1", rd_n(0), busy_n[6]);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (rd_b(0) !== '0 || rd_n(0) !== '0 || busy_b !== '0 || busy_n !== '0) begin
            errors++; $display("FAIL async_reset got %h %h busy %h want 0", rd_b(0), rd_n(0), busy_b);
        end
        @(negedge clk);
        set_wr(0, 5'd9, 64'h99); set_alloc(0, 5'd9);
        #1;
        checks++;
        if (rd_b(1) !== '0 || rbusy_b !== '0) begin
            errors++; $display("FAIL reset_bypass got %h rbusy %b want 0", rd_b(1), rbusy_b);
        end
        @(negedge clk);
        reset = 1'b0; idle();
        #1;
        checks++;
        if (rd_b(1) !== '0 || rd_n(1) !== '0 || busy_n !== '0) begin
            errors++; $display("FAIL reset_discard got %h busy %h want 0", rd_n(1), busy_n);
        end
    endtask

    task automatic test_conflict();
        @(negedge clk);
        raddr = {4{5'd7}};
        set_wr(0, 5'd7, 64'hAAAA); set_wr(1, 5'd7, 64'h5555);
        #1;
        checks++;
        if (rd_b(0) !== 64'h5555 || rd_n(0) !== 64'h0) begin
            errors++; $display("FAIL conflict_bypass got %h/%h want 5555/0", rd_b(0), rd_n(0));
        end
        @(negedge clk); idle();
        #1;
        checks++;
        if (rd_b(3) !== 64'h5555 || rd_n(2) !== 64'h5555) begin
            errors++; $display("FAIL conflict_stored got %h/%h want 5555", rd_b(3), rd_n(2));
        end
    endtask

    task automatic test_x0();
        @(negedge clk);
        raddr = '0;
        set_wr(0, 5'd0, 64'hFFFF); set_alloc(0, 5'd0);
        #1;
        checks++;
        if (rd_b(0) !== '0 || rbusy_b[0] !== 1'b0 || rd_n(0) !== '0) begin
            errors++; $display("FAIL x0_same got %h rbusy %b want 0", rd_b(0), rbusy_b[0]);
        end
        @(negedge clk); idle();
        #1;
        checks++;
        if (rd_b(0) !== '0 || rd_n(0) !== '0 || busy_b[0] !== 1'b0 || busy_n[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
            errors++; $display("FAIL x0_after got %h busy0 %b want 0", rd_n(0), busy_n[0]);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        raddr = {15'd0, 5'd10};
        set_wr(1, 5'd10, 64'h111); set_alloc(0, 5'd10);
        @(negedge clk); idle();
        set_wr(0, 5'd10, 64'hFFF);
        #1;
        checks++;
        if (rd_b(0) !== 64'hFFF || rbusy_b[0] !== 1'b0) begin
            errors++; $display("FAIL bypass_on got %h rbusy %b want fff/0", rd_b(0), rbusy_b[0]);
        end
        checks++;
        if (rd_n(0) !== 64'h111 || rbusy_n[0] !== 1'b1) begin
            errors++; $display("FAIL bypass_off got %h rbusy %b want 111/1", rd_n(0), rbusy_n[0]);
        end
        @(negedge clk); idle();
        #1;
        checks++;
        if (rd_b(0) !== 64'hFFF || rd_n(0) !== 64'hFFF || busy_n[10] !== 1'b0) begin
            errors++; $display("FAIL bypass_next got %h/%h busy %b want fff/0", rd_b(0), rd_n(0), busy_n[10]);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        raddr = {15'd0, 5'd3};
        set_alloc(1, 5'd3);
        #1;
        checks++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b0) begin
            errors++; $display("FAIL sb_before got %b/%b want 0", rbusy_b[0], rbusy_n[0]);
        end
        @(negedge clk); idle();
        #1;
        checks++;
        if (rbusy_b[0] !== 1'b1 || rbusy_n[0] !== 1'b1 || busy_b !== 32'h0000_0008) begin
            errors++; $display("FAIL sb_alloc got %b busy %h want 1/00000008", rbusy_b[0], busy_b);
        end
        set_wr(0, 5'd3, 64'h33); set_alloc(1, 5'd3);
        #1;
        checks++;
        if (rbusy_b[0] !== 1'b0 || rbusy_n[0] !== 1'b1) begin
            errors++; $display("FAIL sb_hit got %b/%b want 0/1", rbusy_b[0], rbusy_n[0]);
        end
        @(negedge clk); idle();
        #1;
        checks++;
        if (busy_b[3] !== 1'b1 || busy_n[3] !== 1'b1 || rd_n(0) !== 64'h33) begin
            errors++; $display("FAIL sb_setwins got %b data %h want 1/33", busy_n[3], rd_n(0));
        end
        set_wr(1, 5'd3, 64'h44);
        @(negedge clk); idle();
        #1;
        checks++;
        if (busy_b !== 32'h0 || rbusy_n[0] !== 1'b0 || rd_n(0) !== 64'h44) begin
            errors++; $display("FAIL sb_clear got busy %h data %h want 0/44", busy_b, rd_n(0));
        end
    endtask

    task automatic test_sweep();
        logic [XLEN-1:0] expv [32];
        for (int i = 0; i < 32; i++) expv[i] = 64'(i * 3);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); idle();
            set_wr(0, 5'(2*c + 1), 64'((2*c + 1) * 3));
            if (c < 15) set_wr(1, 5'(2*c + 2), 64'((2*c + 2) * 3));
        end
        @(negedge clk); idle();
        for (int g = 0; g < 8; g++) begin
            for (int r = 0; r < NRD; r++) raddr[r*5 +: 5] = 5'(g*4 + r);
            #1;
            for (int r = 0; r < NRD; r++) begin
                checks++;
                if (rd_b(r) !== expv[g*4 + r] || rd_n(r) !== expv[g*4 + r]) begin
                    errors++;
                    $display("FAIL sweep_x%0d got %h/%h want %h", g*4 + r, rd_b(r), rd_n(r), expv[g*4 + r]);
                end
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_conflict();
        test_x0();
        test_bypass();
        test_scoreboard();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
